// File: rtl/compress_pkg.sv
// ---------------------------------------------------------------------------
// compress_pkg
// Shared types and constants for the compression front-end.
//   seq_state_t : sequencer FSM encoding
//   WORD_W      : dictionary word width
//   DW_W        : double-word width presented to the matching stage
//   PAGE_WORDS  : 64-bit words per compression block (4 KiB page)
// ---------------------------------------------------------------------------
package compress_pkg;

   localparam int WORD_W     = 32;
   localparam int DW_W       = 64;
   localparam int PAGE_WORDS = 512;

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} seq_state_t;

endpackage

// File: rtl/pipe_reg_1.sv
// ---------------------------------------------------------------------------
// pipe_reg_1
// Single-entry valid/ready register. Loads on in_valid_i & in_ready_o and
// holds its payload stable until the consumer takes it. A load and a pop in
// the same cycle replace the entry with no bubble.
//   clk_i, rst_i           : clock, async active-high reset
//   in_valid_i/in_ready_o  : producer handshake
//   in_data_i              : payload in
//   out_valid_o/out_ready_i: consumer handshake
//   out_data_o             : registered payload
// ---------------------------------------------------------------------------
module pipe_reg_1 #(
   parameter int W = 66
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   logic         load;

   always_comb begin
      in_ready_o = out_ready_i | ~valid_q;
      load       = in_valid_i & in_ready_o;
      valid_d    = valid_q;
      data_d     = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = in_data_i;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

endmodule

// File: rtl/compress_sequencer.sv
// ---------------------------------------------------------------------------
// compress_sequencer
// Splits the uncompressed stream into fixed-size blocks for the 64-bit
// matching stage. Each block is preceded by a one-cycle dictionary clear;
// first/last words are tagged; back-pressure is passed to the source.
//   i_clk, i_reset          : clock, async active-high reset
//   i_valid/o_ready         : source handshake, i_data word, i_last short block
//   o_word/o_word_valid     : registered word to matching stage (+ o_first/o_last)
//   i_down_ready            : downstream consumes o_word
//   o_dict_clear            : one-cycle dictionary clear pulse
//   i_dict_full/o_dict_wrapped : dictionary full flag / sticky per-block wrap
//   o_word_cnt              : words accepted in current block
//   o_block_done            : last word of block consumed
//   o_busy                  : FSM not idle
// ---------------------------------------------------------------------------
module compress_sequencer
   import compress_pkg::*;
#(
   parameter int WIDTH       = DW_W,
   parameter int BLOCK_WORDS = PAGE_WORDS,
   parameter int CNT_W       = $clog2(BLOCK_WORDS) + 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_last,
   output logic             o_ready,
   output logic [WIDTH-1:0] o_word,
   output logic             o_word_valid,
   output logic             o_first,
   output logic             o_last,
   input  logic             i_down_ready,
   output logic             o_dict_clear,
   input  logic             i_dict_full,
   output logic             o_dict_wrapped,
   output logic [CNT_W-1:0] o_word_cnt,
   output logic             o_block_done,
   output logic             o_busy
);

   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;

   logic             pipe_in_ready;
   logic             run;
   logic             src_xfer;
   logic             down_xfer;
   logic             word_first;
   logic             word_last;

   assign run        = (state_q == RUN);
   // Source only sees ready in RUN; elsewhere the register is empty or draining.
   assign o_ready    = run & pipe_in_ready;
   assign src_xfer   = i_valid & o_ready;
   assign down_xfer  = o_word_valid & i_down_ready;
   assign word_first = (cnt_q == '0);
   assign word_last  = (cnt_q == CNT_W'(BLOCK_WORDS - 1)) | i_last;

   pipe_reg_1 #(.W(WIDTH + 2)) u_pipe (
      .clk_i       (i_clk),
      .rst_i       (i_reset),
      .in_valid_i  (i_valid & run),
      .in_ready_o  (pipe_in_ready),
      .in_data_i   ({word_first, word_last, i_data}),
      .out_valid_o (o_word_valid),
      .out_ready_i (i_down_ready),
      .out_data_o  ({o_first, o_last, o_word})
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      wrap_d       = wrap_q;
      o_dict_clear = 1'b0;
      o_block_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_valid) state_d = CLEAR;
         end
         CLEAR: begin
            o_dict_clear = 1'b1;
            cnt_d        = '0;
            wrap_d       = 1'b0;
            state_d      = RUN;
         end
         RUN: begin
            if (i_dict_full) wrap_d = 1'b1;
            if (src_xfer) begin
               cnt_d = cnt_q + CNT_W'(1);
               // Once the last word is taken no more are accepted, so the
               // counter tops out at BLOCK_WORDS and never wraps.
               if (word_last) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (i_dict_full) wrap_d = 1'b1;
            if (down_xfer) begin
               o_block_done = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
      end
   end

   assign o_word_cnt     = cnt_q;
   assign o_dict_wrapped = wrap_q;
   assign o_busy         = (state_q != IDLE);

endmodule
